// File: rtl/sha3_padder.sv
// sha3_padder: packs a byte stream into SHA3 rate blocks, applies multi-rate
// padding (domain byte + final 0x80) and hands each block to the permutation
// core over a valid/ready handshake.
module sha3_padder #(
    parameter int         RATE_BYTES = 136,
    parameter logic [7:0] DS_BYTE    = 8'h06
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_keep,
    input  logic                    in_last,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [8*RATE_BYTES-1:0] blk_data,
    output logic                    blk_last
);

    localparam int BW = 8 * RATE_BYTES;
    localparam int CW = $clog2(RATE_BYTES + 1);
    localparam logic [CW-1:0] RATE_CNT = CW'(RATE_BYTES);
    // Block holding nothing but padding: domain byte first, 0x80 in the last byte.
    localparam logic [BW-1:0] PAD_BLK = {8'h80, {(BW-16){1'b0}}, DS_BYTE};

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        EMIT_PAD
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            pend_q;
    logic [BW-1:0]   buf_q;
    logic            vld_q;
    logic            last_q;

    logic [CW-1:0]   cnt_nxt;
    logic [BW-1:0]   buf_nxt;
    logic            accept;

    assign in_ready  = (state_q == FILL);
    assign blk_valid = vld_q;
    assign blk_last  = last_q;
    assign blk_data  = buf_q;

    // A keep=0/last=0 beat carries nothing, so it is treated as not accepted.
    assign accept = in_valid && in_ready && (in_keep || in_last);

    // Buffer contents after the current beat: store the byte, then pad if the
    // message ends and there is still room in this block.
    always_comb begin
        cnt_nxt = cnt_q + CW'(in_keep);
        buf_nxt = buf_q;
        if (in_keep) begin
            buf_nxt[cnt_q*8 +: 8] = in_data;
        end
        if (in_last && (cnt_nxt < RATE_CNT)) begin
            buf_nxt[cnt_nxt*8 +: 8] = DS_BYTE;
            buf_nxt[BW-1 -: 8]      = buf_nxt[BW-1 -: 8] | 8'h80;
        end
    end

    // Control FSM with registered block-side outputs; the buffer drives blk_data directly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            buf_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        buf_q <= buf_nxt;
                        cnt_q <= cnt_nxt;
                        if (in_last) begin
                            // A full block ending the message needs a separate pad block.
                            state_q <= EMIT;
                            vld_q   <= 1'b1;
                            if (cnt_nxt == RATE_CNT) begin
                                pend_q <= 1'b1;
                                last_q <= 1'b0;
                            end else begin
                                last_q <= 1'b1;
                            end
                        end else if (cnt_nxt == RATE_CNT) begin
                            state_q <= EMIT;
                            vld_q   <= 1'b1;
                            last_q  <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        cnt_q <= '0;
                        if (pend_q) begin
                            buf_q   <= PAD_BLK;
                            pend_q  <= 1'b0;
                            last_q  <= 1'b1;
                            state_q <= EMIT_PAD;
                        end else begin
                            buf_q   <= '0;
                            vld_q   <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= FILL;
                        end
                    end
                end
                EMIT_PAD: begin
                    if (blk_ready) begin
                        buf_q   <= '0;
                        vld_q   <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule
